// File: rtl/key_debounce.sv
// key_debounce: per-key pushbutton conditioner.
// Each raw active-low key passes through a 2-flop synchronizer and then a
// four-state filter (UP, FILT_DN, DOWN, FILT_UP). The filter publishes a
// debounced level and one-cycle press/release pulses.
// Optional feature macro: KEY_LONG_PRESS_EN adds a per-key hold counter that
// emits one key_long pulse per press once the key has been held LONG_CYCLES.
// When the macro is not defined, key_long is tied to 0.
module key_debounce #(
    parameter int KEY_W           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic             clk_50,
    input  logic             reset_reset,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_long
);

    typedef enum logic [1:0] {
        UP      = 2'd0,
        FILT_DN = 2'd1,
        DOWN    = 2'd2,
        FILT_UP = 2'd3
    } key_fsm_t;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    // The filter leaves on the edge at which its count reaches DEBOUNCE_CYCLES-1,
    // so the decision is taken while the registered count is one below that.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter values outside the legal ranges at elaboration.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777215 ||
        LONG_CYCLES < 2 || LONG_CYCLES > 67108863) begin : g_bad_params
        $error("key_debounce: DEBOUNCE_CYCLES or LONG_CYCLES out of range");
    end

    logic [KEY_W-1:0] sync1_reg;
    logic [KEY_W-1:0] sync2_reg;

    // Two-flop synchronizer; idles at 1 (released) out of reset.
    always_ff @(posedge clk_50) begin
        if (reset_reset) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= key_in;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < KEY_W; gi++) begin : g_key
            key_fsm_t         state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic             level_reg, level_next;
            logic             press_reg, press_next;
            logic             release_reg, release_next;
            logic             key_s;

            assign key_s = sync2_reg[gi];

            // Filter state, count and registered outputs.
            always_ff @(posedge clk_50) begin
                if (reset_reset) begin
                    state_reg   <= UP;
                    cnt_reg     <= '0;
                    level_reg   <= 1'b1;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    state_reg   <= state_next;
                    cnt_reg     <= cnt_next;
                    level_reg   <= level_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                end
            end

            // Next-state logic: a level must hold for DEBOUNCE_CYCLES samples.
            always_comb begin
                state_next   = state_reg;
                cnt_next     = cnt_reg;
                level_next   = level_reg;
                press_next   = 1'b0;
                release_next = 1'b0;
                case (state_reg)
                    UP: begin
                        if (!key_s) begin
                            state_next = FILT_DN;
                            cnt_next   = '0;
                        end
                    end
                    FILT_DN: begin
                        if (key_s) begin
                            state_next = UP;
                            cnt_next   = '0;
                        end else if (cnt_reg >= DB_LAST) begin
                            state_next = DOWN;
                            cnt_next   = DB_MAX;
                            level_next = 1'b0;
                            press_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    DOWN: begin
                        if (key_s) begin
                            state_next = FILT_UP;
                            cnt_next   = '0;
                        end
                    end
                    FILT_UP: begin
                        if (!key_s) begin
                            state_next = DOWN;
                            cnt_next   = '0;
                        end else if (cnt_reg >= DB_LAST) begin
                            state_next   = UP;
                            cnt_next     = DB_MAX;
                            level_next   = 1'b1;
                            release_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = UP;
                        cnt_next   = '0;
                    end
                endcase
            end

            assign key_state[gi]   = level_reg;
            assign key_press[gi]   = press_reg;
            assign key_release[gi] = release_reg;

`ifdef KEY_LONG_PRESS_EN
            localparam int LONG_W = $clog2(LONG_CYCLES);
            localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 2);
            localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES - 1);

            logic [LONG_W-1:0] long_cnt_reg, long_cnt_next;
            logic              long_reg, long_next;

            // Hold-time counter and its one-shot pulse register.
            always_ff @(posedge clk_50) begin
                if (reset_reset) begin
                    long_cnt_reg <= '0;
                    long_reg     <= 1'b0;
                end else begin
                    long_cnt_reg <= long_cnt_next;
                    long_reg     <= long_next;
                end
            end

            // Restart on each new press; keep counting through release
            // bounces; saturate so the pulse fires once per press.
            always_comb begin
                long_cnt_next = long_cnt_reg;
                long_next     = 1'b0;
                if (state_reg == FILT_DN && state_next == DOWN) begin
                    long_cnt_next = '0;
                end else if ((state_reg == DOWN || state_reg == FILT_UP) &&
                             long_cnt_reg != LONG_MAX) begin
                    long_cnt_next = long_cnt_reg + 1'b1;
                    long_next     = (long_cnt_reg == LONG_LAST);
                end
            end

            assign key_long[gi] = long_reg;
`else
            assign key_long[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: table-driven, hand-written and randomized checks of
// key_debounce (KEY_W=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10) against a
// run-length reference model of the debounce rules.
module tb_key_debounce;

    localparam int KW = 2;
    localparam int DB = 4;
    localparam int LC = 10;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic          clk_50;
    logic          reset_reset;
    logic [KW-1:0] key_in;
    logic [KW-1:0] key_state;
    logic [KW-1:0] key_press;
    logic [KW-1:0] key_release;
    logic [KW-1:0] key_long;

    key_debounce #(
        .KEY_W          (KW),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LC)
    ) dut (
        .clk_50     (clk_50),
        .reset_reset(reset_reset),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    initial begin
        clk_50 = 1'b0;
        forever #5 clk_50 = ~clk_50;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: sample pipe, run length of the synchronized level,
    // debounced level and cycles held since the last press.
    bit  m_p1[KW], m_p2[KW], m_lvl[KW], m_runval[KW];
    int  m_run[KW], m_since[KW];
    bit [KW-1:0] e_state, e_press, e_rel, e_long;

    task automatic check(input string name, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    task automatic model_step();
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        for (int k = 0; k < KW; k++) begin
            if (reset_reset) begin
                m_p1[k] = 1'b1; m_p2[k] = 1'b1; m_lvl[k] = 1'b1;
                m_runval[k] = 1'b1; m_run[k] = 0; m_since[k] = 0;
            end else begin
                bit s;
                s = m_p2[k];
                m_p2[k] = m_p1[k];
                m_p1[k] = key_in[k];
                if (!m_lvl[k]) begin
                    m_since[k]++;
                    if (m_since[k] == LC - 1) e_long[k] = LONG_EN;
                end
                if (s == m_runval[k]) m_run[k]++;
                else begin
                    m_runval[k] = s;
                    m_run[k] = 1;
                end
                if (m_run[k] >= DB && s != m_lvl[k]) begin
                    m_lvl[k] = s;
                    if (!s) begin
                        e_press[k] = 1'b1;
                        m_since[k] = 0;
                    end else begin
                        e_rel[k] = 1'b1;
                    end
                end
            end
            e_state[k] = m_lvl[k];
        end
    endtask

    // One clock: model advances on the edge, outputs compared at the falling edge.
    task automatic tick();
        @(posedge clk_50);
        model_step();
        @(negedge clk_50);
        check("model_state",   key_state,   e_state);
        check("model_press",   key_press,   e_press);
        check("model_release", key_release, e_rel);
        check("model_long",    key_long,    e_long);
    endtask

    typedef struct {
        bit       rst;
        bit [1:0] key;
        int       n;
        bit [1:0] st;
        bit [1:0] pr;
        bit [1:0] rl;
    } vec_t;

    vec_t tbl[23];

    int press_n, long_n, rel_n, long_at;

    initial begin
        reset_reset = 1'b1;
        key_in      = 2'b11;

        // reset, clean press/release of key 0
        tbl[0]  = '{1'b1, 2'b11, 2, 2'b11, 2'b00, 2'b00};
        tbl[1]  = '{1'b0, 2'b10, 5, 2'b11, 2'b00, 2'b00};
        tbl[2]  = '{1'b0, 2'b10, 1, 2'b10, 2'b01, 2'b00};
        tbl[3]  = '{1'b0, 2'b10, 2, 2'b10, 2'b00, 2'b00};
        tbl[4]  = '{1'b0, 2'b11, 5, 2'b10, 2'b00, 2'b00};
        tbl[5]  = '{1'b0, 2'b11, 1, 2'b11, 2'b00, 2'b01};
        tbl[6]  = '{1'b0, 2'b11, 2, 2'b11, 2'b00, 2'b00};
        // bounce shorter than the filter
        tbl[7]  = '{1'b0, 2'b10, 3, 2'b11, 2'b00, 2'b00};
        tbl[8]  = '{1'b0, 2'b11, 8, 2'b11, 2'b00, 2'b00};
        // both keys together
        tbl[9]  = '{1'b0, 2'b00, 5, 2'b11, 2'b00, 2'b00};
        tbl[10] = '{1'b0, 2'b00, 1, 2'b00, 2'b11, 2'b00};
        tbl[11] = '{1'b0, 2'b00, 2, 2'b00, 2'b00, 2'b00};
        tbl[12] = '{1'b0, 2'b11, 5, 2'b00, 2'b00, 2'b00};
        tbl[13] = '{1'b0, 2'b11, 1, 2'b11, 2'b00, 2'b11};
        tbl[14] = '{1'b0, 2'b11, 2, 2'b11, 2'b00, 2'b00};
        // reset in the middle of a filter
        tbl[15] = '{1'b0, 2'b10, 3, 2'b11, 2'b00, 2'b00};
        tbl[16] = '{1'b1, 2'b10, 1, 2'b11, 2'b00, 2'b00};
        tbl[17] = '{1'b0, 2'b10, 5, 2'b11, 2'b00, 2'b00};
        tbl[18] = '{1'b0, 2'b10, 1, 2'b10, 2'b01, 2'b00};
        tbl[19] = '{1'b0, 2'b10, 2, 2'b10, 2'b00, 2'b00};
        tbl[20] = '{1'b0, 2'b11, 5, 2'b10, 2'b00, 2'b00};
        tbl[21] = '{1'b0, 2'b11, 1, 2'b11, 2'b00, 2'b01};
        tbl[22] = '{1'b0, 2'b11, 2, 2'b11, 2'b00, 2'b00};

        for (int v = 0; v < 23; v++) begin
            for (int c = 0; c < tbl[v].n; c++) begin
                reset_reset = tbl[v].rst;
                key_in      = tbl[v].key;
                tick();
                check($sformatf("tbl%0d_state", v),   key_state,   tbl[v].st);
                check($sformatf("tbl%0d_press", v),   key_press,   tbl[v].pr);
                check($sformatf("tbl%0d_release", v), key_release, tbl[v].rl);
                check($sformatf("tbl%0d_long", v),    key_long,    2'b00);
            end
            $display("vector %0d: rst=%0b key=%b x%0d state=%b press=%b release=%b",
                     v, tbl[v].rst, tbl[v].key, tbl[v].n, key_state, key_press, key_release);
        end

        // Long press on key 1: one press, one long pulse 9 cycles later, no repeat.
        press_n = 0; long_n = 0; long_at = -1; rel_n = 0;
        key_in = 2'b01;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (key_press[1]) press_n++;
            if (key_long[1]) begin
                long_n++;
                long_at = i;
            end
        end
        key_in = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (key_release[1]) rel_n++;
            if (key_long[1]) long_n++;
        end
        check("long_press_count",   2'(press_n), 2'd1);
        check("long_pulse_count",   2'(long_n), LONG_EN ? 2'd1 : 2'd0);
        check("long_release_count", 2'(rel_n), 2'd1);
        total++;
        if (long_at != (LONG_EN ? 14 : -1)) begin
            bad++;
            $display("FAIL long_pulse_cycle got=%0d exp=%0d", long_at, LONG_EN ? 14 : -1);
        end
        $display("long press: presses=%0d longs=%0d at=%0d releases=%0d", press_n, long_n, long_at, rel_n);

        // Randomized: per-key hold lengths mixing bounces and long holds, rare resets.
        begin
            int hold[KW];
            for (int k = 0; k < KW; k++) hold[k] = 0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                for (int k = 0; k < KW; k++) begin
                    if (hold[k] == 0) begin
                        key_in[k] = 1'($urandom_range(0, 1));
                        hold[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 25))
                                                               : int'($urandom_range(1, 6));
                    end
                    hold[k]--;
                end
                reset_reset = ($urandom_range(0, 99) == 0);
                tick();
                if (key_press != 0 || key_release != 0 || key_long != 0)
                    $display("rand %0d: rst=%0b key=%b state=%b press=%b release=%b long=%b",
                             cyc, reset_reset, key_in, key_state, key_press, key_release, key_long);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter KEY_W, default 2, giving the number of keys.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the stable-input time (20 ms at 50 MHz), legal range 2..2^24-1.
REQ-003 The block SHALL have parameter LONG_CYCLES, default 50000000, giving the long-press hold time, legal range 2..2^26-1.
REQ-004 The block SHALL have port clk_50, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port reset_reset, input, 1 bit: the reset is synchronous and active-high.
REQ-006 The block SHALL have port key_in, input, KEY_W bits: raw asynchronous pushbuttons, active-low (0 = pressed).
REQ-007 The block SHALL have port key_state, output, KEY_W bits: debounced level, active-low, wired directly to pio_key_export.
REQ-008 The block SHALL have port key_press, output, KEY_W bits: a one-cycle pulse per key on a debounced press.
REQ-009 The block SHALL have port key_release, output, KEY_W bits: a one-cycle pulse per key on a debounced release.
REQ-010 The block SHALL have port key_long, output, KEY_W bits: a one-cycle pulse per key when a press has been held LONG_CYCLES.

Function
REQ-011 Each key bit SHALL pass through a 2-flop synchronizer before any other logic; all keys are fully independent.
REQ-012 Each key SHALL run an FSM with states UP, FILT_DN, DOWN, FILT_UP.
REQ-013 In UP, a synchronized 0 SHALL move the FSM to FILT_DN with the debounce counter cleared to 0.
REQ-014 In FILT_DN, the counter SHALL increment each cycle the synchronized input stays 0; a synchronized 1 returns the FSM to UP and clears the counter (bounce rejected, no pulse).
REQ-015 In FILT_DN, when the counter equals DEBOUNCE_CYCLES-1 with input still 0, the FSM SHALL enter DOWN on the same edge that drives key_state low and key_press high for exactly one cycle.
REQ-016 DOWN/FILT_UP SHALL mirror REQ-013..015 with polarity inverted; the entry to UP drives key_state high and pulses key_release.
REQ-017 A clean input edge SHALL appear on key_state exactly DEBOUNCE_CYCLES+2 rising edges after key_in is first sampled at the new level.
REQ-018 Pulses shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change and no pulse.
REQ-019 key_press and key_release of one key SHALL never assert in the same cycle; different keys MAY pulse in the same cycle.
REQ-020 Counters SHALL saturate and never wrap; counter width SHALL be clog2 of the parameter.

Reset
REQ-021 While reset_reset=1 at a clock edge: synchronizer flops=1, FSM=UP, counters=0, key_state=all 1s, key_press/key_release/key_long=0.
REQ-022 A reset asserted mid-filter or mid-press SHALL discard that state; no pulse SHALL be emitted on reset entry or exit.
REQ-023 After reset release with a key held low, the press SHALL be reported per REQ-017, counted from the first post-reset sample.

Configuration
REQ-024 With macro KEY_LONG_PRESS_EN defined, each key SHALL have a long counter that clears on entry to DOWN, increments in DOWN and FILT_UP, and pulses key_long once when it reaches LONG_CYCLES-1.
REQ-025 Under KEY_LONG_PRESS_EN, key_long SHALL NOT repeat until the key has been released and pressed again.
REQ-026 Under KEY_LONG_PRESS_EN, a bounce (FILT_UP returning to DOWN) SHALL NOT clear the long counter.
REQ-027 With KEY_LONG_PRESS_EN undefined, key_long SHALL be constant 0 and no long-press counter logic SHALL exist.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, KEY_W=2)
REQ-028 Clean press: key_in[0] 1->0 held -> key_state[0]=0 and key_press[0]=1 for one cycle on the 6th edge; key_state[1] stays 1.
REQ-029 Bounce: key_in[0] low 3 cycles, then high -> no key_press, key_state stays 2'b11.
REQ-030 Release: after the press in REQ-028, key_in[0] 0->1 held -> key_release[0] single pulse on the 6th edge, key_state=2'b11.
REQ-031 Long press (macro on): key_in[1] held low 20 cycles -> key_press[1] once, then key_long[1] once 9 cycles later, no repeat; with the macro off, key_long=0 throughout.
REQ-032 Reset mid-filter: key_in[0] low 3 cycles, reset_reset=1 for 1 cycle, key_in[0] still low -> no pulse during reset; key_press[0] 6 edges after reset drops.
REQ-033 Simultaneous: both keys pressed on the same cycle -> key_press=2'b11 in one cycle, key_state=2'b00.
